// File: rtl/glm_dot_arbiter.sv
// rtl/glm_dot_arbiter.sv - round-robin arbiter/sequencer sharing one glm_dot unit
//
// Purpose:
//    Shares a single glm_dot compute unit between NUM_REQUESTERS instruction
//    issuers. A granted requester's 6-word register file is latched onto
//    dot_regs, dot_op_start is pulsed, and when dot_op_done returns a one-cycle
//    done pulse goes back to that requester. Also keeps an issue counter, a
//    sticky watchdog flag for stalled operations and a sticky flag for
//    unexpected completion pulses.
//
// Ports:
//    clk, reset      clock, synchronous active-high reset
//    req             level request per requester, held until its done
//    req_regs        packed register files, requester i at [i*192 +: 192]
//    grant           one-hot grant, high from issue until done
//    done            one-cycle completion pulse to the granted requester
//    dot_op_start    start pulse to the dot unit
//    dot_op_done     completion pulse from the dot unit
//    dot_regs        latched register file for the dot unit
//    busy            operation outstanding
//    active_id       index of the granted requester (valid while busy)
//    num_issued      wrapping count of operations started
//    err_timeout     sticky watchdog flag
//    err_spurious    sticky flag, dot_op_done seen outside WAIT
//
// NUM_REQUESTERS is 2..4 and ID_WIDTH must cover it; TIMEOUT_CYCLES=0
// disables the watchdog.

module glm_dot_arbiter #(
   parameter int NUM_REQUESTERS = 2,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQUESTERS-1:0]     req,
   input  logic [NUM_REQUESTERS*192-1:0] req_regs,
   output logic [NUM_REQUESTERS-1:0]     grant,
   output logic [NUM_REQUESTERS-1:0]     done,
   output logic                          dot_op_start,
   input  logic                          dot_op_done,
   output logic [191:0]                  dot_regs,
   output logic                          busy,
   output logic [ID_WIDTH-1:0]           active_id,
   output logic [31:0]                   num_issued,
   output logic                          err_timeout,
   output logic                          err_spurious
);

   localparam int          REG_W   = 192;
   localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] ptr;
   logic [31:0]         wd_cnt;

   // Round-robin pick: first set bit at or above the pointer, otherwise the
   // lowest set bit (the wrap-around part of the search).
   logic                found;
   logic [ID_WIDTH-1:0] sel;
   logic [REG_W-1:0]    sel_regs;
   logic [ID_WIDTH-1:0] next_ptr;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (!found && req[i] && (ID_WIDTH'(i) >= ptr)) begin
            found = 1'b1;
            sel   = ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            sel   = ID_WIDTH'(i);
         end
      end
   end

   // Mux written with constant slices so each branch is a fixed wire range.
   always_comb begin
      sel_regs = '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (sel == ID_WIDTH'(i)) begin
            sel_regs = req_regs[i*REG_W +: REG_W];
         end
      end
   end

   always_comb begin
      next_ptr = '0;
      if (active_id != ID_WIDTH'(NUM_REQUESTERS - 1)) begin
         next_ptr = active_id + ID_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         wd_cnt       <= '0;
         grant        <= '0;
         done         <= '0;
         dot_op_start <= 1'b0;
         dot_regs     <= '0;
         busy         <= 1'b0;
         active_id    <= '0;
         num_issued   <= '0;
         err_timeout  <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         dot_op_start <= 1'b0;
         done         <= '0;
         case (state)
            ST_IDLE: begin
               if (dot_op_done) begin
                  err_spurious <= 1'b1;
               end
               if (found) begin
                  state        <= ST_WAIT;
                  for (int i = 0; i < NUM_REQUESTERS; i++) begin
                     grant[i] <= (sel == ID_WIDTH'(i));
                  end
                  active_id    <= sel;
                  dot_regs     <= sel_regs;
                  dot_op_start <= 1'b1;
                  busy         <= 1'b1;
                  num_issued   <= num_issued + 32'd1;
                  wd_cnt       <= '0;
               end
            end

            ST_WAIT: begin
               // Saturating watchdog; the flag only reports, the arbiter
               // keeps waiting for the real completion.
               if (TIMEOUT_CYCLES > 0) begin
                  if (wd_cnt != TMO_LIM) begin
                     wd_cnt <= wd_cnt + 32'd1;
                     if (wd_cnt + 32'd1 == TMO_LIM) begin
                        err_timeout <= 1'b1;
                     end
                  end
               end
               if (dot_op_done) begin
                  // A completion coincident with our own start pulse cannot
                  // belong to this operation.
                  if (dot_op_start) begin
                     err_spurious <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     grant <= '0;
                     busy  <= 1'b0;
                     ptr   <= next_ptr;
                     for (int i = 0; i < NUM_REQUESTERS; i++) begin
                        done[i] <= (active_id == ID_WIDTH'(i));
                     end
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glm_dot_arbiter.sv
// tb/tb_glm_dot_arbiter.sv - self-checking bench for glm_dot_arbiter

module tb_glm_dot_arbiter;

   localparam int N   = 3;
   localparam int IDW = 2;
   localparam int TMO = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*192-1:0] req_regs;
   logic [N-1:0]     grant;
   logic [N-1:0]     done;
   logic             dot_op_start;
   logic             dot_op_done;
   logic [191:0]     dot_regs;
   logic             busy;
   logic [IDW-1:0]   active_id;
   logic [31:0]      num_issued;
   logic             err_timeout;
   logic             err_spurious;

   glm_dot_arbiter #(
      .NUM_REQUESTERS(N),
      .ID_WIDTH      (IDW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_regs    (req_regs),
      .grant       (grant),
      .done        (done),
      .dot_op_start(dot_op_start),
      .dot_op_done (dot_op_done),
      .dot_regs    (dot_regs),
      .busy        (busy),
      .active_id   (active_id),
      .num_issued  (num_issued),
      .err_timeout (err_timeout),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails  = 0;
   int          m_ptr;
   int unsigned m_issued;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      req         = '0;
      dot_op_done = 1'b0;
      tick();
      tick();
      reset    = 1'b0;
      m_ptr    = 0;
      m_issued = 0;
   endtask

   function automatic logic [N*192-1:0] rand_regs();
      logic [N*192-1:0] v;
      for (int w = 0; w < N * 6; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference round-robin rule: first requester at or after ptr, modulo N.
   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(int i);
      return N'(1 << i);
   endfunction

   task automatic test_reset();
      reset = 1'b1; req = '0; dot_op_done = 1'b0; req_regs = rand_regs();
      tick();
      reset = 1'b0;
      checks++;
      if ({grant, done, dot_op_start, busy} !== '0) begin
         fails++; $display("FAIL reset_ctrl grant=%b done=%b start=%b busy=%b expected all 0", grant, done, dot_op_start, busy);
      end
      checks++;
      if (dot_regs !== '0 || active_id !== '0 || num_issued !== 32'd0) begin
         fails++; $display("FAIL reset_data dot_regs=%h active_id=%0d num_issued=%0d expected 0", dot_regs, active_id, num_issued);
      end
      checks++;
      if (err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
         fails++; $display("FAIL reset_flags timeout=%b spurious=%b expected 0 0", err_timeout, err_spurious);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_regs = rand_regs();
      req_regs[3*32 +: 32] = 32'h0001_0008;
      req = 3'b001;
      tick();
      checks++;
      if (dot_op_start !== 1'b1 || grant !== 3'b001 || busy !== 1'b1) begin
         fails++; $display("FAIL single_issue start=%b grant=%b busy=%b expected 1 001 1", dot_op_start, grant, busy);
      end
      checks++;
      if (dot_regs[3*32 +: 32] !== 32'h0001_0008 || dot_regs !== req_regs[191:0]) begin
         fails++; $display("FAIL single_regs word3=%h expected 00010008", dot_regs[3*32 +: 32]);
      end
      checks++;
      if (num_issued !== 32'd1) begin
         fails++; $display("FAIL single_count num_issued=%0d expected 1", num_issued);
      end
      tick();
      checks++;
      if (dot_op_start !== 1'b0) begin
         fails++; $display("FAIL single_start_pulse start=%b expected 0", dot_op_start);
      end
      repeat (17) tick();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      req = '0;
      checks++;
      if (done !== 3'b001 || busy !== 1'b0 || grant !== 3'b000) begin
         fails++; $display("FAIL single_done done=%b busy=%b grant=%b expected 001 0 000", done, busy, grant);
      end
      tick();
      checks++;
      if (done !== 3'b000) begin
         fails++; $display("FAIL single_done_pulse done=%b expected 000", done);
      end
   endtask

   task automatic test_contention();
      int exp_id;
      do_reset();
      req_regs = rand_regs();
      req = 3'b011;
      for (int op = 0; op < 6; op++) begin
         exp_id = pick(req, m_ptr);
         tick();
         m_issued++;
         checks++;
         if (dot_op_start !== 1'b1 || grant !== onehot(exp_id) || active_id !== IDW'(exp_id)) begin
            fails++; $display("FAIL contention_grant op=%0d start=%b grant=%b id=%0d expected 1 %b %0d", op, dot_op_start, grant, active_id, onehot(exp_id), exp_id);
         end
         repeat ($urandom_range(1, 5)) tick();
         dot_op_done = 1'b1;
         tick();
         dot_op_done = 1'b0;
         checks++;
         if (done !== onehot(exp_id)) begin
            fails++; $display("FAIL contention_done op=%0d done=%b expected %b", op, done, onehot(exp_id));
         end
         m_ptr = (exp_id + 1) % N;
      end
      req = '0;
      checks++;
      if (num_issued !== m_issued || m_issued != 6) begin
         fails++; $display("FAIL contention_count num_issued=%0d expected 6", num_issued);
      end
   endtask

   task automatic test_regs_stability();
      logic [191:0] held;
      int           bad;
      do_reset();
      req_regs = rand_regs();
      req = 3'b001;
      held = req_regs[191:0];
      tick();
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         req_regs = rand_regs();
         req = 3'($urandom_range(0, 7));
         tick();
         if (dot_regs !== held || grant !== 3'b001) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++; $display("FAIL regs_stability %0d cycles changed dot_regs=%h grant=%b expected %h 001", bad, dot_regs, grant, held);
      end
      req = '0;
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      checks++;
      if (done !== 3'b001) begin
         fails++; $display("FAIL regs_done done=%b expected 001", done);
      end
   endtask

   task automatic test_spurious();
      do_reset();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      checks++;
      if (err_spurious !== 1'b1 || done !== 3'b000 || busy !== 1'b0) begin
         fails++; $display("FAIL spurious_idle spurious=%b done=%b busy=%b expected 1 000 0", err_spurious, done, busy);
      end
      tick();
      checks++;
      if (done !== 3'b000 || busy !== 1'b0 || dot_op_start !== 1'b0) begin
         fails++; $display("FAIL spurious_idle_after done=%b busy=%b start=%b expected 000 0 0", done, busy, dot_op_start);
      end
      // Completion coincident with the start pulse must be ignored.
      do_reset();
      req = 3'b100;
      tick();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      checks++;
      if (err_spurious !== 1'b1 || busy !== 1'b1 || done !== 3'b000) begin
         fails++; $display("FAIL spurious_start spurious=%b busy=%b done=%b expected 1 1 000", err_spurious, busy, done);
      end
      tick();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      req = '0;
      checks++;
      if (done !== 3'b100 || busy !== 1'b0) begin
         fails++; $display("FAIL spurious_recover done=%b busy=%b expected 100 0", done, busy);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      req = 3'b010;
      tick();
      repeat (TMO - 1) tick();
      checks++;
      if (err_timeout !== 1'b0) begin
         fails++; $display("FAIL watchdog_early timeout=%b expected 0 after %0d cycles", err_timeout, TMO - 1);
      end
      tick();
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL watchdog_limit timeout=%b busy=%b expected 1 1", err_timeout, busy);
      end
      repeat (40 - TMO) tick();
      checks++;
      if (busy !== 1'b1 || grant !== 3'b010 || done !== 3'b000) begin
         fails++; $display("FAIL watchdog_hold busy=%b grant=%b done=%b expected 1 010 000", busy, grant, done);
      end
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      req = '0;
      checks++;
      if (done !== 3'b010 || busy !== 1'b0) begin
         fails++; $display("FAIL watchdog_done done=%b busy=%b expected 010 0", done, busy);
      end
      tick();
      checks++;
      if (err_timeout !== 1'b1 || err_spurious !== 1'b0) begin
         fails++; $display("FAIL watchdog_sticky timeout=%b spurious=%b expected 1 0", err_timeout, err_spurious);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      req_regs = rand_regs();
      req = 3'b001;
      tick();
      repeat (5) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({grant, done, dot_op_start, busy, err_timeout, err_spurious} !== '0 || dot_regs !== '0 || num_issued !== 32'd0 || active_id !== '0) begin
         fails++; $display("FAIL midreset_outputs grant=%b done=%b start=%b busy=%b count=%0d expected all 0", grant, done, dot_op_start, busy, num_issued);
      end
      reset = 1'b0;
      req = 3'b010;
      tick();
      checks++;
      if (grant !== 3'b010 || active_id !== IDW'(1) || num_issued !== 32'd1 || dot_regs !== req_regs[192 +: 192]) begin
         fails++; $display("FAIL midreset_regrant grant=%b id=%0d count=%0d expected 010 1 1", grant, active_id, num_issued);
      end
      tick();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
      // Pointer must now be 2, so requesters 0 and 2 together pick 2.
      req = 3'b101;
      tick();
      checks++;
      if (grant !== 3'b100) begin
         fails++; $display("FAIL midreset_pointer grant=%b expected 100", grant);
      end
      req = '0;
      tick();
      dot_op_done = 1'b1;
      tick();
      dot_op_done = 1'b0;
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [191:0] held;
      int           exp_id;
      int           bad;
      do_reset();
      for (int op = 0; op < 40; op++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) tick();
            checks++;
            if (busy !== 1'b0 || dot_op_start !== 1'b0) begin
               fails++; $display("FAIL random_idle op=%0d busy=%b start=%b expected 0 0", op, busy, dot_op_start);
            end
         end
         r = N'($urandom_range(1, 7));
         req = r;
         req_regs = rand_regs();
         exp_id = pick(r, m_ptr);
         held = req_regs[exp_id*192 +: 192];
         m_issued++;
         tick();
         checks++;
         if (dot_op_start !== 1'b1 || grant !== onehot(exp_id) || active_id !== IDW'(exp_id) || dot_regs !== held || num_issued !== m_issued) begin
            fails++; $display("FAIL random_issue op=%0d req=%b grant=%b id=%0d count=%0d expected %b %0d %0d", op, r, grant, active_id, num_issued, onehot(exp_id), exp_id, m_issued);
         end
         bad = 0;
         repeat ($urandom_range(1, 8)) begin
            req_regs = rand_regs();
            req = N'($urandom_range(0, 7));
            tick();
            if (dot_regs !== held || busy !== 1'b1 || grant !== onehot(exp_id)) bad++;
         end
         checks++;
         if (bad != 0) begin
            fails++; $display("FAIL random_wait op=%0d %0d bad cycles", op, bad);
         end
         req = '0;
         dot_op_done = 1'b1;
         tick();
         dot_op_done = 1'b0;
         checks++;
         if (done !== onehot(exp_id) || busy !== 1'b0) begin
            fails++; $display("FAIL random_done op=%0d done=%b busy=%b expected %b 0", op, done, busy, onehot(exp_id));
         end
         m_ptr = (exp_id + 1) % N;
      end
      checks++;
      if (err_timeout !== 1'b0 || err_spurious !== 1'b0) begin
         fails++; $display("FAIL random_flags timeout=%b spurious=%b expected 0 0", err_timeout, err_spurious);
      end
   endtask

   initial begin
      reset = 1'b1; req = '0; req_regs = '0; dot_op_done = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_regs_stability();
      test_spurious();
      test_watchdog();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/glm_dot_arbiter.md
Name: glm_dot_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one glm_dot compute unit between NUM_REQUESTERS instruction issuers, e.g. several per-engine instruction decoders in the GLM pipeline.
- Grants one requester and latches its 6-word register file onto the dot unit's regs input. Pulses op_start, waits for op_done, then returns a done pulse to the granted requester.
- Also provides an issue counter and a sticky watchdog for stalled operations.

Parameters:
- NUM_REQUESTERS, default 2: number of requesters, legal range 2..4.
- ID_WIDTH, default 2: width of active_id; must be at least ceil(log2(NUM_REQUESTERS)).
- TIMEOUT_CYCLES, default 0: watchdog limit in cycles spent in WAIT; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQUESTERS  level request per requester; held until that requester's done.
- req_regs  in  NUM_REQUESTERS*192  packed register files; requester i occupies [i*192 +: 192], word k is [k*32 +: 32].
- grant  out  NUM_REQUESTERS  one-hot grant; high from issue until done.
- done  out  NUM_REQUESTERS  one-cycle completion pulse to the granted requester.
- dot_op_start  out  1  start pulse to the dot unit.
- dot_op_done  in  1  completion pulse from the dot unit.
- dot_regs  out  192  latched register file driven to the dot unit (word k at [k*32 +: 32]).
- busy  out  1  high while an operation is outstanding.
- active_id  out  ID_WIDTH  index of the granted requester; valid while busy.
- num_issued  out  32  count of operations started, wrapping at 2^32.
- err_timeout  out  1  sticky watchdog flag.
- err_spurious  out  1  sticky flag: dot_op_done arrived outside WAIT.

Behaviour:
- All outputs are registered.
- Reset values: grant=0, done=0, dot_op_start=0, dot_regs=0, busy=0, active_id=0, num_issued=0, err_timeout=0, err_spurious=0. The round-robin pointer resets to 0 and the state to IDLE.
- States: IDLE, WAIT.
- IDLE, cycle t, any req bit high:
  - Select the first set bit at or after the pointer, wrapping modulo NUM_REQUESTERS.
  - At t+1: grant[sel]=1, active_id=sel, dot_regs=req_regs slice sel, dot_op_start=1 for exactly one cycle, busy=1, num_issued+1, state becomes WAIT.
  - Fixed latency from req to start is 1 cycle.
- dot_regs is frozen for the whole WAIT state. Changes on req_regs or req during WAIT are ignored.
- WAIT, dot_op_done high at cycle d:
  - At d+1: done[active_id]=1 for one cycle, grant=0, busy=0, pointer=(active_id+1) mod NUM_REQUESTERS, state becomes IDLE.
  - IDLE at d+1 evaluates req normally, so back-to-back operations start at d+2 at the earliest.
- A requester whose req is still high at d+1 is a new request, arbitrated fairly against the others.
- A req bit that drops before being granted is a withdrawn request; no done is produced for it.
- dot_op_done while in IDLE, or in the same cycle dot_op_start is asserted: ignored, err_spurious set.
- Watchdog (TIMEOUT_CYCLES>0):
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set. The state remains WAIT and the arbiter keeps waiting for dot_op_done.
  - The counter saturates; it does not wrap.
- Sticky flags clear only on reset.
- Reset mid-operation: returns to IDLE the next cycle with all reset values. No done is emitted. The dot unit is reset by the same signal.
- No combinational path from req or dot_op_done to any output.

Test Plan:
- Single requester, NUM_REQUESTERS=2: req[0]=1, regs word3=0x0001_0008 at t -> at t+1 dot_op_start=1, grant=01, dot_regs word3=0x0001_0008, num_issued=1; dot_op_done at t+20 -> done=01 at t+21, busy=0.
- Contention: req=11 held from t, pointer 0 -> requester 0 granted first. After its done, requester 1 starts 1 cycle later (done cycle+1). After that done, requester 0 is regranted; grants strictly alternate over 6 operations and num_issued=6.
- Regs stability: requester 0 changes req_regs every cycle during WAIT -> dot_regs is unchanged until the next issue.
- Spurious done: dot_op_done pulsed in IDLE -> err_spurious=1, no done pulse, state stays IDLE.
- Watchdog, TIMEOUT_CYCLES=16: dot_op_done withheld 40 cycles -> err_timeout=1 once 16 cycles have elapsed in WAIT, busy stays 1; final dot_op_done still yields a normal done pulse.
- Reset mid-WAIT: reset asserted 5 cycles after start -> next cycle all outputs 0 and pointer 0; a subsequent req[1] is granted with num_issued=1.
